// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with freeze buffering,
// delayed-branch redirect handling and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  output logic [31:0] Imem_Addr_OUT,
  output logic        Imem_Req_OUT,
  input  logic        Imem_Ready_IN,
  input  logic        Imem_Valid_IN,
  input  logic [31:0] Imem_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] Instr1_PC_Plus4_OUT
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
  logic [31:0] buf_q, buf_d, instr_q, instr_d, pc_q, pc_d, pc4_q, pc4_d;
  logic squash_q, squash_d, pend_q, pend_d, out_valid_q, out_valid_d;
  logic accept, resp, kill, redir_b, have, deliver;
  logic [31:0] word;
  assign Imem_Req_OUT = RESET && state_q == S_REQ && !WANT_FREEZE_IN;
  assign Imem_Addr_OUT = addr_q;
  assign Instr1_OUT = instr_q;
  assign Instr1_PC_OUT = pc_q;
  assign Instr1_PC_Plus4_OUT = pc4_q;
  assign accept = Imem_Req_OUT && Imem_Ready_IN;
  assign resp = Imem_Valid_IN && state_q == S_WAIT;
  // kill squashes whatever is in flight or buffered: flush, or a redirect after the delay slot
  assign kill = FLUSH || (Request_Alt_PC_IN && out_valid_q);
  assign redir_b = Request_Alt_PC_IN && !out_valid_q && !FLUSH;
  assign have = (resp && !squash_q) || state_q == S_HOLD;
  assign word = state_q == S_HOLD ? buf_q : Imem_Data_IN;
  assign deliver = have && !kill && !WANT_FREEZE_IN;
  always_comb begin
    state_d = state_q;
    squash_d = squash_q;
    buf_d = buf_q;
    fetch_pc_d = fetch_pc_q;
    if (accept) begin
      state_d = S_WAIT;
      squash_d = kill;
      fetch_pc_d = addr_q;
    end else if (state_q == S_WAIT) begin
      if (resp) begin
        state_d = (have && !kill && WANT_FREEZE_IN) ? S_HOLD : S_REQ;
        squash_d = 1'b0;
        buf_d = Imem_Data_IN;
      end else begin
        squash_d = squash_q || kill;
      end
    end else if (state_q == S_HOLD && (kill || !WANT_FREEZE_IN)) begin
      state_d = S_REQ;
    end
    addr_d = FLUSH ? (Request_Alt_PC_IN ? Alt_PC_IN : fetch_pc_d)
           : (Request_Alt_PC_IN && out_valid_q) ? Alt_PC_IN
           : (deliver && (redir_b || pend_q)) ? (redir_b ? Alt_PC_IN : pend_pc_q)
           : accept ? addr_q + 32'd4 : addr_q;
    pend_d = kill ? 1'b0 : redir_b ? !deliver : deliver ? 1'b0 : pend_q;
    pend_pc_d = redir_b ? Alt_PC_IN : pend_pc_q;
    instr_d = deliver ? word : (WANT_FREEZE_IN && !FLUSH) ? instr_q : 32'd0;
    out_valid_d = deliver ? 1'b1 : (WANT_FREEZE_IN && !FLUSH) ? out_valid_q : 1'b0;
    pc_d = deliver ? fetch_pc_q : pc_q;
    pc4_d = deliver ? fetch_pc_q + 32'd4 : pc4_q;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_REQ;
      addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      pend_pc_q <= 32'd0;
      buf_q <= 32'd0;
      instr_q <= 32'd0;
      pc_q <= 32'd0;
      pc4_q <= 32'd0;
      squash_q <= 1'b0;
      pend_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q <= pend_pc_d;
      buf_q <= buf_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      pc4_q <= pc4_d;
      squash_q <= squash_d;
      pend_q <= pend_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, first fetch address after reset.
REQ-002 Clock and reset are decided as follows: one clock; reset is asynchronous and active-low.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: RESET  input  1  asynchronous active-low reset.
REQ-005 Port: FLUSH  input  1  squash fetch state and deliver a bubble.
REQ-006 Port: Alt_PC_IN  input  32  redirect target from decode.
REQ-007 Port: Request_Alt_PC_IN  input  1  one-cycle redirect request from decode.
REQ-008 Port: WANT_FREEZE_IN  input  1  decode requests fetch hold.
REQ-009 Port: Imem_Addr_OUT  output  32  instruction memory address, registered.
REQ-010 Port: Imem_Req_OUT  output  1  request valid; accepted when Imem_Ready_IN=1 in the same cycle.
REQ-011 Port: Imem_Ready_IN  input  1  memory accepts request.
REQ-012 Port: Imem_Valid_IN  input  1  response valid, at least 1 cycle after acceptance.
REQ-013 Port: Imem_Data_IN  input  32  instruction word, qualified by Imem_Valid_IN.
REQ-014 Port: Instr1_OUT  output  32  instruction to decode; 0 = bubble.
REQ-015 Port: Instr1_PC_OUT  output  32  PC of Instr1_OUT.
REQ-016 Port: Instr1_PC_Plus4_OUT  output  32  Instr1_PC_OUT+4, modulo 2^32.

Function
REQ-017 FSM states: REQ (Imem_Req_OUT=1), WAIT (1 outstanding request), HOLD (response buffered).
REQ-018 Transitions: REQ->WAIT on Req&Ready; WAIT->REQ on Valid when not frozen; WAIT->HOLD on Valid while WANT_FREEZE_IN=1; HOLD->REQ when WANT_FREEZE_IN=0.
REQ-019 At most one outstanding request at all times.
REQ-020 In REQ with WANT_FREEZE_IN=1, Imem_Req_OUT=0 and the address is held.
REQ-021 On acceptance, the accepted address is latched as fetch_pc, and Imem_Addr_OUT advances to fetch_pc+4 (wraps at 2^32) unless a redirect applies.
REQ-022 Delivery: an unsquashed response with WANT_FREEZE_IN=0 sets Instr1_OUT, PC_OUT and PC_Plus4_OUT at the next edge and sets out_valid=1.
REQ-023 Bubble: any cycle without a delivery sets Instr1_OUT=0, keeps the PC outputs and clears out_valid.
REQ-024 While WANT_FREEZE_IN=1, Instr1_OUT and the PC outputs hold their values, not a bubble.
REQ-025 Leaving HOLD delivers the buffered word at the first edge with WANT_FREEZE_IN=0.
REQ-026 Redirect case A, Request_Alt_PC_IN=1 with out_valid=1: the delay slot is already delivered.
REQ-027 Case A: any in-flight request, including one accepted in the same cycle, is marked squashed, and Imem_Addr_OUT becomes Alt_PC_IN at the next edge.
REQ-028 Redirect case B, Request_Alt_PC_IN=1 with out_valid=0: the next delivered instruction is the delay slot.
REQ-029 Case B: Alt_PC_IN is latched as pending, and the first fetch address after that delivery is the pending target.
REQ-030 A newer redirect overwrites a pending one.
REQ-031 A squashed response is discarded: bubble delivered, state goes to REQ at Imem_Addr_OUT.
REQ-032 FLUSH: Instr1_OUT becomes 0, the buffer is cleared, any in-flight request is squashed, and the pending redirect is cleared.
REQ-033 FLUSH: the address becomes fetch_pc, or Alt_PC_IN if Request_Alt_PC_IN=1 in the same cycle.
REQ-034 FLUSH has priority over freeze.
REQ-035 Simultaneous Valid and FLUSH: the response is dropped.

Reset
REQ-036 While RESET=0: Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT and Imem_Req_OUT are 0, Imem_Addr_OUT=RESET_PC, state=REQ, and the squash, pending and out_valid flags are 0.
REQ-037 Reset asserted mid-request abandons the request; a late Imem_Valid_IN after release is ignored unless a request has been accepted.
REQ-038 In the first cycle after release, Imem_Req_OUT=1.

Verification
REQ-039 Ready=1, latency 1 -> deliveries of 0x0040_0000, 0x0040_0004, 0x0040_0008, each followed by one bubble, with PC_Plus4 correct.
REQ-040 Freeze asserted during WAIT for 3 cycles -> Instr1_OUT is held, the response is buffered (HOLD), and it is delivered the edge after release with no request issued meanwhile.
REQ-041 Redirect to 0x0040_0100 while out_valid=0 -> the delay slot at branch+4 is delivered, and the next request address is 0x0040_0100.
REQ-042 Redirect to 0x0040_0200 while out_valid=1, with an accepted request to 0x0040_0010 -> its response is discarded as a bubble, and the next request address is 0x0040_0200.
REQ-043 FLUSH with latency 3 mid-WAIT -> Instr1_OUT=0, the response is dropped, and the same fetch_pc is re-requested.
REQ-044 Imem_Addr_OUT=0xFFFF_FFFC accepted -> the next address is 0x0000_0000, and PC_Plus4_OUT=0x0000_0000.
